aes_round_ctrl: RTL and testbench
=================================

# aes_round_ctrl

Iterative AES-128 round sequencer that drives the shared single-round datapath: state register, SubBytes/ShiftRows/MixColumns, and the AddRoundKey XOR stage. It accepts a start request and fetches round keys from the key-expansion block over a valid handshake. It steps the datapath through the initial AddRoundKey, rounds 1..NR-1 and the final round (MixColumns skipped), then holds the result valid until the consumer takes it. The block produces control only; the 128-bit data never passes through it.

## Interface
- NR, 10, number of cipher rounds (AES-128); legal values 2..15
- RW, 4, width of round counter and key index; must satisfy 2^RW > NR
- i_clk  input  1  clock; all logic on the rising edge
- i_rst  input  1  synchronous, active-high reset
- i_start  input  1  start request; accepted when o_ready=1
- i_abort  input  1  cancel the current operation; return to IDLE
- i_key_valid  input  1  round key for o_key_idx is present on the key bus
- i_out_ready  input  1  consumer accepts the result while o_valid=1
- o_ready  output  1  IDLE and able to accept i_start
- o_busy  output  1  operation in progress (any state except IDLE)
- o_key_req  output  1  round key requested
- o_key_idx  output  RW  index of the requested round key
- o_round  output  RW  current round number, 0..NR
- o_sel_init  output  1  datapath mux selects plaintext XOR key (round 0)
- o_skip_mix  output  1  bypass MixColumns (final round)
- o_state_we  output  1  state register write enable
- o_valid  output  1  ciphertext in the state register is valid

## Operation
- States: IDLE, RUN, DONE.
- IDLE: o_ready=1. On i_start=1 go to RUN with round=0.
- RUN: o_key_req=1 and o_key_idx=round.
  - o_state_we = i_key_valid.
  - o_sel_init=(round==0); o_skip_mix=(round==NR). Both are valid every RUN cycle, independent of i_key_valid.
  - On a write with round<NR, round increments. On a write with round==NR, go to DONE.
  - With i_key_valid=0, hold: no write, round unchanged, no limit on stall length.
- DONE: o_valid=1 and o_round=NR. On i_out_ready=1 go to IDLE. In DONE, i_start is ignored.
- i_abort=1 in RUN or DONE: go to IDLE next cycle with no write that cycle (o_state_we forced 0) and no o_valid. In IDLE, i_abort is ignored.
- i_abort and i_start both high in IDLE: start wins.
- Round counter is RW bits and never wraps. It is cleared on entry to RUN and held at NR in DONE.
- All outputs are decoded from the state register and round counter; the only exception is o_state_we, which also depends on i_key_valid.

## Timing
- Reset: state=IDLE, round=0. o_ready=1; o_busy, o_key_req, o_state_we, o_sel_init, o_skip_mix and o_valid are 0; o_key_idx=0, o_round=0.
- A start accepted at edge E puts the block in RUN from cycle E+1.
- With i_key_valid held at 1 there are NR+1 consecutive write cycles (E+1..E+NR+1), and o_valid rises at E+NR+2 (E+12 for NR=10).
- Each stall cycle adds exactly one cycle of latency.
- Result handoff: o_valid stays high until the cycle in which i_out_ready=1. o_ready returns one cycle later, so the earliest back-to-back start is one cycle after the handoff.
- Reset asserted mid-operation takes effect at the next edge. No write is issued in that cycle.

## Configuration
- AES_DECRYPT_EN defined: adds input i_mode (1 bit, sampled on start acceptance and held for the whole operation).
  - With i_mode=1, o_key_idx = NR-round, giving the descending key order for the inverse cipher. o_sel_init and o_skip_mix are unchanged; the datapath interprets them as the inverse round.
  - With i_mode=0, behaviour is identical to the undefined case.
- AES_DECRYPT_EN undefined: there is no i_mode port, and o_key_idx = round always.

## Test plan
- Reset, then i_start with i_key_valid=1 throughout, NR=10 -> writes on 11 consecutive cycles with o_key_idx 0..10; o_sel_init only on the first write, o_skip_mix only on the last; o_valid at start+12.
- i_key_valid low for 3 cycles at round 4 -> o_round stays 4 with no write; o_valid at start+15.
- i_out_ready held 0 for 5 cycles in DONE, with i_start pulsed -> o_valid stays 1 and the start is ignored; o_ready rises the cycle after i_out_ready=1.
- i_abort at round 6 -> o_state_we=0 that cycle; next cycle IDLE with o_ready=1 and no o_valid; a following start restarts from round 0.
- i_rst asserted at round 3 -> all outputs at reset values on the next cycle.
- AES_DECRYPT_EN with i_mode=1 -> o_key_idx 10,9,...,0 across the 11 writes.

Source files
------------

// File: rtl/aes_round_ctrl.sv
// Iterative AES round sequencer: IDLE -> RUN (round 0..NR) -> DONE, control only.
// Optional AES_DECRYPT_EN adds i_mode for descending key order (inverse cipher).
//   state | meaning
//   IDLE  | ready for i_start
//   RUN   | request key o_key_idx, write state on each i_key_valid
//   DONE  | ciphertext valid, wait for i_out_ready
module aes_round_ctrl #(
    parameter int NR = 10,
    parameter int RW = 4
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic          i_abort,
    input  logic          i_key_valid,
    input  logic          i_out_ready,
`ifdef AES_DECRYPT_EN
    input  logic          i_mode,
`endif
    output logic          o_ready,
    output logic          o_busy,
    output logic          o_key_req,
    output logic [RW-1:0] o_key_idx,
    output logic [RW-1:0] o_round,
    output logic          o_sel_init,
    output logic          o_skip_mix,
    output logic          o_state_we,
    output logic          o_valid
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [RW-1:0] LP_NR = RW'(NR);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [RW-1:0] r_round;
    logic [RW-1:0] w_round_nxt;
    logic [RW-1:0] w_key_idx;

`ifdef AES_DECRYPT_EN
    logic r_mode;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mode <= 1'b0;
        end else if (r_state == ST_IDLE && i_start) begin
            r_mode <= i_mode;
        end
    end

    assign w_key_idx = r_mode ? (LP_NR - r_round) : r_round;
`else
    assign w_key_idx = r_round;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_round <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_round <= w_round_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_round_nxt = r_round;
        o_ready     = 1'b0;
        o_busy      = 1'b0;
        o_key_req   = 1'b0;
        o_sel_init  = 1'b0;
        o_skip_mix  = 1'b0;
        o_state_we  = 1'b0;
        o_valid     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                o_ready = 1'b1;
                if (i_start) begin
                    w_state_nxt = ST_RUN;
                    w_round_nxt = '0;
                end
            end
            ST_RUN: begin
                o_busy     = 1'b1;
                o_key_req  = 1'b1;
                o_sel_init = (r_round == '0);
                o_skip_mix = (r_round == LP_NR);
                // reset and abort both suppress the write of the cycle they land in
                o_state_we = i_key_valid & ~i_abort & ~i_rst;
                if (i_abort) begin
                    w_state_nxt = ST_IDLE;
                    w_round_nxt = '0;
                end else if (i_key_valid) begin
                    if (r_round == LP_NR) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_round_nxt = r_round + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                o_busy  = 1'b1;
                o_valid = 1'b1;
                if (i_abort || i_out_ready) begin
                    w_state_nxt = ST_IDLE;
                    w_round_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_round_nxt = '0;
            end
        endcase
    end

    assign o_round   = r_round;
    assign o_key_idx = (r_state == ST_RUN) ? w_key_idx : '0;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench for aes_round_ctrl: per-cycle vector table plus latency/decrypt sequences.
module tb_aes_round_ctrl;

    localparam int NR = 10;
    localparam int RW = 4;

    logic          clk;
    logic          rst;
    logic          start;
    logic          abort_r;
    logic          kv;
    logic          ordy;
    logic          mode;
    logic          o_ready;
    logic          o_busy;
    logic          o_key_req;
    logic [RW-1:0] o_key_idx;
    logic [RW-1:0] o_round;
    logic          o_sel_init;
    logic          o_skip_mix;
    logic          o_state_we;
    logic          o_valid;

    aes_round_ctrl #(.NR(NR), .RW(RW)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .i_abort     (abort_r),
        .i_key_valid (kv),
        .i_out_ready (ordy),
`ifdef AES_DECRYPT_EN
        .i_mode      (mode),
`endif
        .o_ready     (o_ready),
        .o_busy      (o_busy),
        .o_key_req   (o_key_req),
        .o_key_idx   (o_key_idx),
        .o_round     (o_round),
        .o_sel_init  (o_sel_init),
        .o_skip_mix  (o_skip_mix),
        .o_state_we  (o_state_we),
        .o_valid     (o_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // packed outputs: {ready,busy,key_req,key_idx,round,sel_init,skip_mix,state_we,valid}
    typedef struct {
        bit          rst;
        bit          start;
        bit          abort;
        bit          kv;
        bit          ordy;
        logic [14:0] exp;
    } vec_t;

    vec_t        vecs[$];
    logic [14:0] sb[$];
    int          n_checks = 0;
    int          n_pass = 0;

    function automatic logic [14:0] e_idle();
        return {1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    endfunction

    function automatic logic [14:0] e_run(input int r, input bit we);
        logic [3:0] rr;
        rr = 4'(r);
        return {1'b0, 1'b1, 1'b1, rr, rr, (r == 0), (r == NR), we, 1'b0};
    endfunction

    function automatic logic [14:0] e_done();
        return {1'b0, 1'b1, 1'b0, 4'd0, 4'(NR), 1'b0, 1'b0, 1'b0, 1'b1};
    endfunction

    function automatic void add(input bit r, input bit s, input bit a, input bit k,
                                input bit o, input logic [14:0] e);
        vec_t v;
        v.rst = r; v.start = s; v.abort = a; v.kv = k; v.ordy = o; v.exp = e;
        vecs.push_back(v);
    endfunction

    function automatic logic [14:0] got_outs();
        return {o_ready, o_busy, o_key_req, o_key_idx, o_round,
                o_sel_init, o_skip_mix, o_state_we, o_valid};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s got=%0h want=%0h", name, got, want);
    endtask

    initial begin
        logic [14:0] w;
        int          cyc;
        rst = 1'b1; start = 1'b0; abort_r = 1'b0; kv = 1'b0; ordy = 1'b0; mode = 1'b0;

        // full run, key always valid, immediate handoff
        add(0, 0, 0, 0, 0, e_idle());
        add(0, 1, 0, 1, 0, e_idle());
        for (int r = 0; r <= NR; r++) add(0, 0, 0, 1, 0, e_run(r, 1));
        add(0, 0, 0, 0, 1, e_done());
        add(0, 0, 0, 0, 0, e_idle());
        // stall 3 cycles at round 4; DONE held with ignored starts
        add(0, 1, 0, 1, 0, e_idle());
        for (int r = 0; r < 4; r++) add(0, 0, 0, 1, 0, e_run(r, 1));
        for (int k = 0; k < 3; k++) add(0, 0, 0, 0, 0, e_run(4, 0));
        for (int r = 4; r <= NR; r++) add(0, 0, 0, 1, 0, e_run(r, 1));
        for (int k = 0; k < 5; k++) add(0, bit'(k % 2), 0, 0, 0, e_done());
        add(0, 0, 0, 0, 1, e_done());
        // back-to-back start, then abort at round 6
        add(0, 1, 0, 1, 0, e_idle());
        for (int r = 0; r < 6; r++) add(0, 0, 0, 1, 0, e_run(r, 1));
        add(0, 0, 1, 1, 0, e_run(6, 0));
        add(0, 0, 0, 0, 0, e_idle());
        // start beats abort in IDLE; restart from round 0; abort in DONE
        add(0, 1, 1, 1, 0, e_idle());
        add(0, 0, 0, 0, 0, e_run(0, 0));
        for (int r = 0; r <= NR; r++) add(0, 0, 0, 1, 0, e_run(r, 1));
        add(0, 0, 1, 0, 0, e_done());
        add(0, 0, 0, 0, 0, e_idle());
        // abort ignored in IDLE
        add(0, 0, 1, 0, 0, e_idle());
        add(0, 0, 0, 0, 0, e_idle());
        // reset at round 3
        add(0, 1, 0, 1, 0, e_idle());
        for (int r = 0; r < 3; r++) add(0, 0, 0, 1, 0, e_run(r, 1));
        add(1, 0, 0, 1, 0, e_run(3, 0));
        add(0, 0, 0, 0, 0, e_idle());

        repeat (2) @(posedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst = vecs[i].rst; start = vecs[i].start; abort_r = vecs[i].abort;
            kv = vecs[i].kv; ordy = vecs[i].ordy;
            sb.push_back(vecs[i].exp);
            #1;
            w = sb.pop_front();
            check($sformatf("vec%0d", i), 32'(got_outs()), 32'(w));
        end

        // latency: o_valid at start+12 with key always valid
        @(negedge clk);
        rst = 1'b0; start = 1'b1; abort_r = 1'b0; kv = 1'b1; ordy = 1'b0;
        @(posedge clk);
        cyc = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            #1;
        end while (!o_valid && cyc < 40);
        check("valid_latency", 32'(cyc), 32'(NR + 2));
        ordy = 1'b1;
        @(negedge clk);
        ordy = 1'b0;
        #1;
        check("ready_after_handoff", 32'(o_ready), 32'd1);
        check("valid_dropped", 32'(o_valid), 32'd0);

`ifdef AES_DECRYPT_EN
        // descending key order; i_mode changes mid-run must not matter
        @(negedge clk);
        start = 1'b1; mode = 1'b1; kv = 1'b1;
        for (int r = 0; r <= NR; r++) begin
            @(negedge clk);
            start = 1'b0; mode = 1'b0;
            #1;
            check($sformatf("dec_idx%0d", r), 32'(o_key_idx), 32'(NR - r));
            check($sformatf("dec_we%0d", r), 32'(o_state_we), 32'd1);
        end
        @(negedge clk);
        ordy = 1'b1;
        #1;
        check("dec_valid", 32'(o_valid), 32'd1);
        @(negedge clk);
        ordy = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
